// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: occupancy states and NOP defaults.
// Imported by every stage boundary that instantiates pipe_skid_stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_DATA_W_DEF = 32;
    localparam int unsigned PIPE_CNT_W_DEF  = 16;
    localparam int unsigned PIPE_DATA_W_MAX = 512;

    // Widest NOP payload; narrower stages take the low DATA_W bits.
    localparam logic [PIPE_DATA_W_MAX-1:0] PIPE_NOP_DEF = '0;

endpackage

// File: rtl/pipe_data_slot.sv
// One payload register with load enable and synchronous clear-to-NOP.
// Clear has priority over load so reset and flush always win.
module pipe_data_slot
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_W    = PIPE_DATA_W_DEF,
    parameter logic [DATA_W-1:0]    NOP_VALUE = DATA_W'(PIPE_NOP_DEF)
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= NOP_VALUE;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages: registered in_ready, one cycle of
// latency, full throughput, flush to NOP and a saturating back-pressure counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_W    = PIPE_DATA_W_DEF,
    parameter logic [DATA_W-1:0]    NOP_VALUE = DATA_W'(PIPE_NOP_DEF),
    parameter int unsigned          CNT_W     = PIPE_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    pipe_state_e       state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_fire, out_fire;
    logic              main_ld, main_from_skid, skid_ld, slot_clr;
    logic [DATA_W-1:0] main_d, main_q, skid_q;

    // Handshake outputs depend only on registered state, never on out_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_valid ? main_q : NOP_VALUE;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign stall_cnt = stall_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_ld = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_d = ST_TWO;
                    skid_ld = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d        = ST_ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush discards any handshake that coincides with it.
        if (flush) begin
            state_d = ST_EMPTY;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign slot_clr = rst | flush;
    assign main_d   = main_from_skid ? skid_q : in_data;

    pipe_data_slot #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP_VALUE)
    ) u_main (
        .clk   (clk),
        .clr_i (slot_clr),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_data_slot #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid (
        .clk   (clk),
        .clr_i (slot_clr),
        .ld_i  (skid_ld),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: throughput, back-pressure, drain order,
// flush, counter saturation and reset priority, with hand-computed expectations.
module tb_pipe_skid_stage;

    localparam int unsigned    DATA_W = 32;
    localparam int unsigned    CNT_W  = 4;
    localparam logic [31:0]    NOP    = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [CNT_W-1:0] exp_stall);
        chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".out_data"},  64'(out_data),  64'(NOP));
        chk({tag, ".occ"},       64'(occupancy), 64'd0);
        chk({tag, ".stall"},     64'(stall_cnt), 64'(exp_stall));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        step();
        step();
        chk_idle("reset", 4'd0);
        rst = 1'b0;

        // Full throughput: data 1..8 with out_ready held high.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            chk($sformatf("tput.in_ready%0d", i), 64'(in_ready), 64'd1);
            step();
            chk($sformatf("tput.data%0d", i), 64'(out_data), 64'(i));
            chk($sformatf("tput.occ%0d", i), 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk_idle("drain", 4'd0);

        // Back-pressure: 0xA and 0xB accepted, 0xC held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        chk("bp.occA", 64'(occupancy), 64'd1);
        chk("bp.stallA", 64'(stall_cnt), 64'd0);
        in_data = 32'hB;
        chk("bp.readyB", 64'(in_ready), 64'd1);
        step();
        chk("bp.occB", 64'(occupancy), 64'd2);
        chk("bp.stallB", 64'(stall_cnt), 64'd1);
        in_data = 32'hC;
        chk("bp.readyC", 64'(in_ready), 64'd0);
        step();
        chk("bp.occC", 64'(occupancy), 64'd2);
        chk("bp.stallC", 64'(stall_cnt), 64'd2);
        chk("bp.dataC", 64'(out_data), 64'hA);
        step();
        chk("bp.readyC2", 64'(in_ready), 64'd0);
        chk("bp.stallC2", 64'(stall_cnt), 64'd3);

        // Drain from TWO with 0xC still offered.
        out_ready = 1'b1;
        chk("drain.A", 64'(out_data), 64'hA);
        step();
        chk("drain.B", 64'(out_data), 64'hB);
        chk("drain.occB", 64'(occupancy), 64'd1);
        chk("drain.readyB", 64'(in_ready), 64'd1);
        step();
        chk("drain.C", 64'(out_data), 64'hC);
        chk("drain.occC", 64'(occupancy), 64'd1);
        in_valid = 1'b0;
        step();
        chk_idle("drain.end", 4'd3);

        // Flush while in TWO with a coincident offer and out_ready.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        chk("fl.occ2", 64'(occupancy), 64'd2);
        chk("fl.stall", 64'(stall_cnt), 64'd4);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h33;
        step();
        chk_idle("flush", 4'd4);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk_idle("flush.after", 4'd4);

        // Counter saturation: stall_cnt starts at 4, 20 back-pressured cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        step();
        in_valid = 1'b0;
        chk("sat.start", 64'(stall_cnt), 64'd4);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 10) chk("sat.k10", 64'(stall_cnt), 64'd14);
            if (k == 11) chk("sat.k11", 64'(stall_cnt), 64'd15);
        end
        chk("sat.end", 64'(stall_cnt), 64'd15);
        chk("sat.data", 64'(out_data), 64'h55);
        chk("sat.occ", 64'(occupancy), 64'd1);

        // Reset in ONE together with flush and an in_fire.
        rst       = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h66;
        out_ready = 1'b1;
        chk("rst.ready_pre", 64'(in_ready), 64'd1);
        step();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_idle("rst", 4'd0);
        step();
        chk_idle("rst.after", 4'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
